// File: rtl/play_pkg.sv
// Shared definitions for the play_ground operand-2 shifter sandbox.
// Holds the srcon shift-operation encodings used by the shifter and the bench.
package play_pkg;

  localparam logic [2:0] SH_LSL = 3'b000;
  localparam logic [2:0] SH_LSR = 3'b001;
  localparam logic [2:0] SH_ASR = 3'b010;
  localparam logic [2:0] SH_ROR = 3'b011;
  localparam logic [2:0] SH_RRX = 3'b100;

endpackage

// File: rtl/play_shifter.sv
// Combinational ARM-style operand-2 barrel shifter.
// Ports:
//   s2_i        operand to be shifted (N bits)
//   shiftb_i    shift amount, unsigned 0..31
//   srcon_i     shift-operation select (see play_pkg)
//   cf_i        carry flag, shifted in by RRX only
//   shift_res_o selected shift result
//   shror_o     s2_i rotated right by (shiftb_i mod N), always computed
module play_shifter
  import play_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] s2_i,
  input  logic [4:0]   shiftb_i,
  input  logic [2:0]   srcon_i,
  input  logic         cf_i,
  output logic [N-1:0] shift_res_o,
  output logic [N-1:0] shror_o
);

  logic [4:0]     rot_amt;
  logic [2*N-1:0] rot_dbl;
  logic           amt_big;

  // Shifting by N or more saturates: zero for logical shifts, sign for ASR.
  assign amt_big = 32'(shiftb_i) >= N;
  assign rot_amt = 5'(32'(shiftb_i) % N);
  // Rotate by shifting a doubled copy; the low half is the rotated value.
  assign rot_dbl = {s2_i, s2_i} >> rot_amt;
  assign shror_o = rot_dbl[N-1:0];

  always_comb begin
    shift_res_o = s2_i;
    unique case (srcon_i)
      SH_LSL:  shift_res_o = amt_big ? '0 : s2_i << shiftb_i;
      SH_LSR:  shift_res_o = amt_big ? '0 : s2_i >> shiftb_i;
      SH_ASR:  shift_res_o = amt_big ? {N{s2_i[N-1]}} : N'($signed(s2_i) >>> shiftb_i);
      SH_ROR:  shift_res_o = shror_o;
      SH_RRX:  shift_res_o = {cf_i, s2_i[N-1:1]};
      default: shift_res_o = s2_i;
    endcase
  end

endmodule

// File: rtl/play_ground.sv
// Shifter-operand datapath sandbox: shifts s2, adds the result to s1 and counts
// leading zeros of the sum. All outputs are registered (one clock of latency).
// Ports:
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   s1          addend operand
//   s2          operand to be shifted
//   shiftb      shift amount 0..31
//   srcon       shift-operation select
//   cf          carry flag in (RRX only)
//   out         registered (s1 + shifted) mod 2^N
//   shifted     registered shifter result
//   count       registered leading-zero count of the sum, 0..N
module play_ground
  import play_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] s1,
  input  logic [N-1:0] s2,
  input  logic [4:0]   shiftb,
  input  logic [2:0]   srcon,
  input  logic         cf,
  output logic [N-1:0] out,
  output logic [N-1:0] shifted,
  output logic [7:0]   count
);

  logic [N-1:0] shift_res;
  logic [N-1:0] shror;
  logic [N-1:0] sum;
  logic [7:0]   clz;
  logic         found;

  logic [N-1:0] out_q, shifted_q;
  logic [7:0]   count_q;

  play_shifter #(
    .N (N)
  ) u_shifter (
    .s2_i        (s2),
    .shiftb_i    (shiftb),
    .srcon_i     (srcon),
    .cf_i        (cf),
    .shift_res_o (shift_res),
    .shror_o     (shror)
  );

  // Carry-out deliberately dropped.
  assign sum = s1 + shift_res;

  // Priority encoder from the MSB; an all-zero sum yields N.
  always_comb begin
    clz   = 8'(N);
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!found && sum[i]) begin
        clz   = 8'(N - 1 - i);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      shifted_q <= '0;
      count_q   <= '0;
    end else begin
      out_q     <= sum;
      shifted_q <= shift_res;
      count_q   <= clz;
    end
  end

  assign out     = out_q;
  assign shifted = shifted_q;
  assign count   = count_q;

endmodule

// File: tb/tb_play_ground.sv
module tb_play_ground;
  import play_pkg::*;

  localparam int unsigned N = 16;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] s1, s2;
  logic [4:0]   shiftb;
  logic [2:0]   srcon;
  logic         cf;
  logic [N-1:0] out, shifted;
  logic [7:0]   count;

  int checks;
  int errors;

  play_ground #(
    .N (N)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s1      (s1),
    .s2      (s2),
    .shiftb  (shiftb),
    .srcon   (srcon),
    .out     (out),
    .shifted (shifted),
    .cf      (cf),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, then sample 1 time unit after the next rising edge.
  task automatic step(input logic [N-1:0] a, input logic [N-1:0] b, input logic [4:0] sh,
                      input logic [2:0] sc, input logic c);
    @(negedge clk);
    s1 = a; s2 = b; shiftb = sh; srcon = sc; cf = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    s1 = 16; s2 = 16; shiftb = 0; srcon = SH_LSL; cf = 1'b1;
    #3;
    check("reset_out", 32'(out), 32'h0);
    check("reset_shifted", 32'(shifted), 32'h0);
    check("reset_count", 32'(count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    step(16, 16, 0, SH_LSL, 1'b1);
    check("lsl0_shifted", 32'(shifted), 32'd16);
    check("lsl0_out", 32'(out), 32'd32);
    check("lsl0_count", 32'(count), 32'd10);
    check("lsl0_shror", 32'(dut.shror), 32'd16);

    step(16, 16, 2, SH_LSL, 1'b1);
    check("lsl2_shifted", 32'(shifted), 32'd64);
    check("lsl2_out", 32'(out), 32'd80);
    check("lsl2_count", 32'(count), 32'd9);

    step(16, 16, 2, SH_LSR, 1'b1);
    check("lsr2_shifted", 32'(shifted), 32'd4);
    check("lsr2_out", 32'(out), 32'd20);

    step(16, 16, 2, SH_ASR, 1'b1);
    check("asr2_shifted", 32'(shifted), 32'd4);

    step(16, 16, 2, SH_ROR, 1'b1);
    check("ror2_shifted", 32'(shifted), 32'd4);
    check("ror2_shror", 32'(dut.shror), 32'd4);

    step(16, 16, 4, SH_LSR, 1'b1);
    check("lsr4_shifted", 32'(shifted), 32'd1);
    check("lsr4_out", 32'(out), 32'd17);

    step(16, 16, 6, SH_LSR, 1'b1);
    check("lsr6_shifted", 32'(shifted), 32'd0);
    check("lsr6_out", 32'(out), 32'd16);
    check("lsr6_count", 32'(count), 32'd11);

    step(16, 16, 20, SH_LSR, 1'b1);
    check("lsr20_shifted", 32'(shifted), 32'd0);

    step(16, 16, 20, SH_LSL, 1'b1);
    check("lsl20_shifted", 32'(shifted), 32'd0);

    // shiftb ignored by RRX: {cf=1, 16>>1} = 0x8008
    step(16, 16, 7, SH_RRX, 1'b1);
    check("rrx_cf1_shifted", 32'(shifted), 32'h8008);

    step(16, 16, 3, 3'b101, 1'b1);
    check("pass_shifted", 32'(shifted), 32'd16);

    step(0, 16'h8001, 1, SH_ASR, 1'b1);
    check("asr1_8001", 32'(shifted), 32'hC000);

    step(0, 16'h8001, 20, SH_ASR, 1'b1);
    check("asr20_8001", 32'(shifted), 32'hFFFF);

    step(0, 16'h8001, 17, SH_ROR, 1'b1);
    check("ror17_8001", 32'(shifted), 32'hC000);
    check("ror17_shror", 32'(dut.shror), 32'hC000);

    step(0, 16'h8001, 0, SH_RRX, 1'b0);
    check("rrx_cf0_8001", 32'(shifted), 32'h4000);
    check("rrx_cf0_count", 32'(count), 32'd1);

    step(16'hFFFF, 1, 0, SH_LSL, 1'b1);
    check("wrap_out", 32'(out), 32'h0);
    check("wrap_count", 32'(count), 32'd16);

    // Mid-stream asynchronous reset, asserted between clock edges.
    step(16, 16, 0, SH_LSL, 1'b1);
    check("pre_rst_out", 32'(out), 32'd32);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'(out), 32'h0);
    check("async_rst_shifted", 32'(shifted), 32'h0);
    check("async_rst_count", 32'(count), 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold_out", 32'(out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(16, 16, 2, SH_LSL, 1'b1);
    check("post_rst_out", 32'(out), 32'd80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
